// File: rtl/result_buffer_pkg.sv
// Shared sizing for the result capture queue.
// Latency: n/a (constants and width helpers only).
// Backpressure: n/a.
package result_buffer_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_DEPTH      = 8;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int PTR_W = ptr_w(DEF_DEPTH);
    localparam int CNT_W = cnt_w(DEF_DEPTH);

endpackage

// File: rtl/result_fifo.sv
// Show-ahead circular FIFO; full/empty come from the occupancy count.
// Latency: a write is visible at rdata the cycle after the push edge.
// Backpressure: a push while full is ignored unless a pop happens in the same cycle.
module result_fifo
    import result_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
) (
    input  logic                      CLK,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      push,
    input  logic                      pop,
    input  logic [DATA_WIDTH-1:0]     wdata,
    output logic [DATA_WIDTH-1:0]     rdata,
    output logic [cnt_w(DEPTH)-1:0]   count,
    output logic                      full,
    output logic                      empty
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  pop_ok;
    logic                  push_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            if (pop_ok)
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is deliberately left out of reset and clear.
    always_ff @(posedge CLK) begin
        if (push_ok && !clear)
            mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/result_buffer.sv
// Captures CPU write-back results on change and queues them for a slow consumer.
// Latency: a captured word appears at out_data/out_valid one cycle after capture.
// Backpressure: out_valid/out_ready; changes arriving while full are dropped and flagged sticky.
module result_buffer
    import result_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
) (
    input  logic                      CLK,
    input  logic                      rst,
    input  logic                      en,
    input  logic [DATA_WIDTH-1:0]     Result_in,
    input  logic                      clear,
    output logic [DATA_WIDTH-1:0]     out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [cnt_w(DEPTH)-1:0]   count,
    output logic                      overflow
);

    logic [DATA_WIDTH-1:0] last_q;
    logic                  has_last;
    logic                  push_req;
    logic                  pop;
    logic                  full;
    logic                  empty;

    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign push_req  = en && (!has_last || (Result_in != last_q));

    result_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .rst   (rst),
        .clear (clear),
        .push  (push_req && !clear),
        .pop   (pop),
        .wdata (Result_in),
        .rdata (out_data),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // The last value is tracked even for dropped pushes so a held value never re-requests.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            last_q   <= '0;
            has_last <= 1'b0;
            overflow <= 1'b0;
        end else if (clear) begin
            has_last <= 1'b0;
            overflow <= 1'b0;
        end else if (push_req) begin
            last_q   <= Result_in;
            has_last <= 1'b1;
            if (full && !pop)
                overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_result_buffer.sv
// Directed and randomized checks of result_buffer against a queue-based reference.
module tb_result_buffer;

    localparam int DEPTH = 8;

    logic        CLK = 1'b0;
    logic        rst;
    logic        en;
    logic [31:0] Result_in;
    logic        clear;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  count;
    logic        overflow;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] mq[$];
    bit          m_has;
    logic [31:0] m_last;
    bit          m_ovf;

    always #5 CLK = ~CLK;

    result_buffer #(.DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
        .CLK       (CLK),
        .rst       (rst),
        .en        (en),
        .Result_in (Result_in),
        .clear     (clear),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .overflow  (overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_has  = 1'b0;
        m_last = '0;
        m_ovf  = 1'b0;
    endtask

    // Called just after a rising edge; applies one cycle of inputs and checks the result.
    task automatic cycle(input logic e, input logic [31:0] d, input logic c, input logic r);
        int   sz;
        logic pr;
        logic pp;
        en = e; Result_in = d; clear = c; out_ready = r;
        @(negedge CLK);
        sz = mq.size();
        check("valid_pre", 32'(out_valid), 32'(sz != 0));
        if (sz != 0)
            check("head", out_data, mq[0]);
        pp = (sz != 0) && r;
        pr = e && (!m_has || d != m_last);
        if (c) begin
            mq.delete();
            m_has = 1'b0;
            m_ovf = 1'b0;
        end else begin
            if (pp)
                void'(mq.pop_front());
            if (pr) begin
                if (sz < DEPTH || pp)
                    mq.push_back(d);
                else
                    m_ovf = 1'b1;
                m_last = d;
                m_has  = 1'b1;
            end
        end
        @(posedge CLK);
        #1;
        check("count", 32'(count), 32'(mq.size()));
        check("valid", 32'(out_valid), 32'(mq.size() != 0));
        check("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; Result_in = '0; clear = 1'b0; out_ready = 1'b0;
        model_reset();
        #2;
        check("rst_count", 32'(count), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        @(posedge CLK);
        #1;
        rst = 1'b0;

        // A held value is captured once.
        repeat (4) cycle(1'b1, 32'h5, 1'b0, 1'b0);
        check("static_count", 32'(count), 32'd1);
        check("static_data", out_data, 32'h5);
        check("static_valid", 32'(out_valid), 32'd1);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Fill past capacity, then drain.
        for (int i = 1; i <= 9; i++) cycle(1'b1, 32'(i), 1'b0, 1'b0);
        check("fill_count", 32'(count), 32'd8);
        check("fill_ovf", 32'(overflow), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            check("drain_data", out_data, 32'(i));
            cycle(1'b0, 32'h0, 1'b0, 1'b1);
        end
        check("drain_count", 32'(count), 32'd0);
        check("drain_ovf", 32'(overflow), 32'd1);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Push and pop together while full.
        for (int i = 1; i <= 8; i++) cycle(1'b1, 32'(i), 1'b0, 1'b0);
        cycle(1'b1, 32'hA, 1'b0, 1'b1);
        check("fullpp_count", 32'(count), 32'd8);
        check("fullpp_ovf", 32'(overflow), 32'd0);
        check("fullpp_head", out_data, 32'h2);
        repeat (7) cycle(1'b0, 32'h0, 1'b0, 1'b1);
        check("fullpp_tail", out_data, 32'hA);
        check("fullpp_left", 32'(count), 32'd1);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Streaming through the pointer wrap.
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 32'(100 + i), 1'b0, 1'b1);
            check("wrap_data", out_data, 32'(100 + i));
            check("wrap_count", 32'(count), 32'd1);
        end
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        check("wrap_empty", 32'(count), 32'd0);

        // Clear wins over a simultaneous push.
        for (int i = 1; i <= 5; i++) cycle(1'b1, 32'(i), 1'b0, 1'b0);
        check("pre_clear", 32'(count), 32'd5);
        cycle(1'b1, 32'h7, 1'b1, 1'b0);
        check("clear_count", 32'(count), 32'd0);
        check("clear_valid", 32'(out_valid), 32'd0);
        check("clear_ovf", 32'(overflow), 32'd0);
        cycle(1'b1, 32'h7, 1'b0, 1'b0);
        check("post_clear_count", 32'(count), 32'd1);
        check("post_clear_data", out_data, 32'h7);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset between edges.
        for (int i = 1; i <= 3; i++) cycle(1'b1, 32'(i), 1'b0, 1'b0);
        check("pre_rst", 32'(count), 32'd3);
        @(negedge CLK);
        #2;
        rst = 1'b1;
        #1;
        check("arst_count", 32'(count), 32'd0);
        check("arst_valid", 32'(out_valid), 32'd0);
        model_reset();
        @(posedge CLK);
        #1;
        rst = 1'b0;
        cycle(1'b1, 32'h3, 1'b0, 1'b0);
        check("post_rst_push", 32'(count), 32'd1);
        check("post_rst_data", out_data, 32'h3);

        // Random traffic: slow consumer, then fast consumer.
        repeat (250) cycle($urandom_range(0, 3) != 0, 32'($urandom_range(0, 3)),
                           $urandom_range(0, 40) == 0, $urandom_range(0, 3) == 0);
        repeat (250) cycle($urandom_range(0, 3) != 0, 32'($urandom_range(0, 5)),
                           $urandom_range(0, 40) == 0, $urandom_range(0, 3) != 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/result_buffer.md
RESULT_BUFFER -- requirements
Module: result_buffer

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of captured result words.
REQ-002 Parameter DEPTH, default 8, number of FIFO entries; must be a power of two and at least 2.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 en  input  1  capture enable; Result_in is sampled only while high (driven by the CPU trigger).
REQ-006 Result_in  input  DATA_WIDTH  write-back Result word from the CPU core.
REQ-007 clear  input  1  synchronous flush request.
REQ-008 out_data  output  DATA_WIDTH  head-of-queue word.
REQ-009 out_valid  output  1  queue non-empty; out_data is meaningful.
REQ-010 out_ready  input  1  consumer (display/UART) accepts out_data this cycle.
REQ-011 count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-012 overflow  output  1  sticky flag: at least one change was dropped because the queue was full.

Function
REQ-013 Change detect: push_req = en && (!has_last || Result_in != last_q); the first sample after reset or clear is always a push request.
REQ-014 last_q/has_last SHALL update on every push_req, whether or not the push is accepted, so a static value never re-requests.
REQ-015 Push accepted when push_req && (count < DEPTH || pop); on acceptance Result_in is written at wr_ptr and wr_ptr advances.
REQ-016 Pop occurs when out_valid && out_ready; rd_ptr advances.
REQ-017 Pointers wrap from DEPTH-1 to 0; full/empty are decided by count, not by pointer compare.
REQ-018 Push and pop in the same cycle when full: both occur, count unchanged, overflow not set.
REQ-019 Push while empty: out_valid rises the cycle after the push edge; there is no same-cycle bypass, so latency is 1 cycle.
REQ-020 Push rejected (full, no pop): the word is dropped, overflow is set and stays set until reset or clear.
REQ-021 out_data = mem[rd_ptr], read combinationally (show-ahead); it is held stable while out_valid && !out_ready.
REQ-022 out_valid = (count != 0); out_data is don't-care when out_valid is 0.
REQ-023 count: +1 on push only, -1 on pop only, unchanged on both or neither.
REQ-024 clear has priority over push/pop: zeroes pointers, count, overflow and has_last next edge; storage contents are not cleared.
REQ-025 A clear and a push_req in the same cycle: the push is discarded, and the next en cycle is treated as a first sample.

Reset
REQ-026 rst asserted: wr_ptr=0, rd_ptr=0, count=0, overflow=0, has_last=0, last_q=0, out_valid=0, immediately and without waiting for a clock edge.
REQ-027 Storage array is not reset.
REQ-028 Reset mid-operation discards all queued entries; the first en cycle after deassertion is a push.

Structure
REQ-029 Shared package result_buffer_pkg holds DEPTH, DATA_WIDTH defaults and the derived PTR_W = $clog2(DEPTH) and CNT_W = PTR_W+1.
REQ-030 Storage and pointers live in one sub-module, result_fifo (push/pop/full/empty/count). Change detection and the overflow flag stay in result_buffer.
REQ-031 result_buffer instantiates beside the CPU top, fed by the core Result and trigger; it adds no logic to the core datapath.

Verification
REQ-032 Reset, then en=1 with Result_in=0x5 for 4 cycles, out_ready=0 -> exactly one entry; count=1, out_data=0x5, out_valid=1 one cycle after the first edge.
REQ-033 en=1, Result_in sequence 1,2,3,...,9 (DEPTH=8), out_ready=0 -> count=8, value 9 dropped, overflow=1; then drain with out_ready=1 -> outputs 1..8 in order, count reaches 0, overflow stays 1.
REQ-034 Full queue, push value 0xA and out_ready=1 in the same cycle -> count stays 8, head advances, 0xA becomes the last entry, overflow=0.
REQ-035 Pointer wrap: push/pop 20 distinct values with out_ready=1 at all times -> every value is output in order exactly once, count never exceeds 1.
REQ-036 clear during count=5 with a simultaneous push of 0x7 -> next cycle count=0, out_valid=0, overflow=0; next en with 0x7 pushes 0x7.
REQ-037 rst asserted asynchronously between clock edges while count=3 -> out_valid=0 and count=0 before the next edge.
